// File: rtl/centimos_euros_seq.sv
// centimos_euros_seq: sequential cents -> euros / fraction converter for the scale price path.
// Restoring division by 100 (one quotient bit per clock) followed by a tens-counting BCD split.
module centimos_euros_seq #(
    parameter int W         = 14,
    parameter int MAX_CENTS = 9999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_cents,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_euros,
    output logic [6:0]   out_frac,
    output logic [3:0]   out_bcd_tens,
    output logic [3:0]   out_bcd_units,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] BCD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int          CW    = $clog2(W);
    localparam logic [31:0] MAX_C = 32'(MAX_CENTS);

    logic [1:0]    r_state;
    logic [W-1:0]  r_dividend;
    logic [W-2:0]  r_quot;
    logic [6:0]    r_rem;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_work;
    logic [3:0]    r_tens;
    logic [W-1:0]  r_euros;
    logic [6:0]    r_frac;
    logic [3:0]    r_bcd_tens;
    logic [3:0]    r_bcd_units;
    logic          r_err;

    logic          w_over;
    logic [7:0]    w_rem_sh;
    logic          w_rem_ge;
    logic [6:0]    w_rem_next;
    logic [W-1:0]  w_quot_next;
    logic          w_work_ge;

    // Stored remainder is always below 100, so 7 bits suffice; the shifted value needs 8.
    assign w_over      = {{(32-W){1'b0}}, in_cents} > MAX_C;
    assign w_rem_sh    = {r_rem, r_dividend[W-1]};
    assign w_rem_ge    = w_rem_sh >= 8'd100;
    assign w_rem_next  = w_rem_ge ? 7'(w_rem_sh - 8'd100) : w_rem_sh[6:0];
    assign w_quot_next = {r_quot, w_rem_ge};
    assign w_work_ge   = r_work >= 7'd10;

    // NOTE: all state uses nonblocking assignments, and every register has a reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dividend  <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_work      <= '0;
            r_tens      <= '0;
            r_euros     <= '0;
            r_frac      <= '0;
            r_bcd_tens  <= '0;
            r_bcd_units <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_over) begin
                            r_euros     <= '0;
                            r_frac      <= '0;
                            r_bcd_tens  <= '0;
                            r_bcd_units <= '0;
                            r_err       <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dividend <= in_cents;
                            r_quot     <= '0;
                            r_rem      <= '0;
                            r_cnt      <= '0;
                            r_state    <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_dividend <= {r_dividend[W-2:0], 1'b0};
                    r_quot     <= w_quot_next[W-2:0];
                    r_rem      <= w_rem_next;
                    r_cnt      <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W-1)) begin
                        r_euros <= w_quot_next;
                        r_frac  <= w_rem_next;
                        r_work  <= w_rem_next;
                        r_tens  <= '0;
                        r_state <= BCD;
                    end
                end
                BCD: begin
                    if (w_work_ge) begin
                        r_work <= r_work - 7'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_bcd_tens  <= r_tens;
                        r_bcd_units <= r_work[3:0];
                        r_err       <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign out_euros     = r_euros;
    assign out_frac      = r_frac;
    assign out_bcd_tens  = r_bcd_tens;
    assign out_bcd_units = r_bcd_units;
    assign out_err       = r_err;

endmodule
